// File: rtl/completion_collector.sv
// completion_collector: per-channel result FIFOs drained round-robin onto registered writeback ports
module completion_collector #(
  parameter int NUM_SRC = 3,
  parameter int NUM_WB = 2,
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int PREG_W = 5,
  parameter int DATA_W = 8,
  parameter int ARCH_W = 4,
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [ROB_W*NUM_SRC-1:0]  src_rob,
  input  logic [PREG_W*NUM_SRC-1:0] src_preg,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  input  logic [ARCH_W*NUM_SRC-1:0] src_arch,
  input  logic                      wb_ready,
  output logic [NUM_WB-1:0]         wb_valid,
  output logic [ROB_W*NUM_WB-1:0]   wb_rob,
  output logic [PREG_W*NUM_WB-1:0]  wb_preg,
  output logic [DATA_W*NUM_WB-1:0]  wb_data,
  output logic [ARCH_W*NUM_WB-1:0]  wb_arch,
  output logic [SW*NUM_WB-1:0]      wb_src,
  output logic                      busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ROB_W + PREG_W + DATA_W + ARCH_W;
  logic [EW-1:0] mem [NUM_SRC][DEPTH];
  logic [PW-1:0] wr_ptr [NUM_SRC];
  logic [PW-1:0] rd_ptr [NUM_SRC];
  logic [CW-1:0] count [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, nz;
  logic [SW-1:0] rr, rr_nxt;
  logic [SW-1:0] sel [NUM_WB];
  logic [EW-1:0] head [NUM_WB];
  logic load_en;
  int nsel;
  assign load_en = wb_ready | ~|wb_valid;
  assign busy = |nz | |wb_valid;
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nz[i] = count[i] != '0;
      src_ready[i] = count[i] != CW'(DEPTH) && !flush;
      push[i] = src_valid[i] & src_ready[i];
    end
  end
  always_comb begin
    pop = '0;
    nsel = 0;
    rr_nxt = rr;
    for (int k = 0; k < NUM_WB; k++) sel[k] = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int i = 0; i < NUM_SRC; i++)
        if ((int'(rr) + s) % NUM_SRC == i && nz[i] && load_en && nsel < NUM_WB) begin
          pop[i] = 1'b1;
          for (int k = 0; k < NUM_WB; k++) if (k == nsel) sel[k] = SW'(i);
          rr_nxt = SW'((i + 1) % NUM_SRC);
          nsel = nsel + 1;
        end
    for (int k = 0; k < NUM_WB; k++) head[k] = mem[sel[k]][rd_ptr[sel[k]]];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {src_rob[ROB_W*i +: ROB_W], src_preg[PREG_W*i +: PREG_W],
                                         src_data[DATA_W*i +: DATA_W], src_arch[ARCH_W*i +: ARCH_W]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      rr <= '0;
      wb_valid <= '0;
      wb_rob <= '0;
      wb_preg <= '0;
      wb_data <= '0;
      wb_arch <= '0;
      wb_src <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      rr <= '0;
      wb_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= wr_ptr[i] + PW'(push[i]);
        rd_ptr[i] <= rd_ptr[i] + PW'(pop[i]);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (load_en) begin
        rr <= rr_nxt;
        for (int k = 0; k < NUM_WB; k++) begin
          wb_valid[k] <= k < nsel;
          if (k < nsel) begin
            {wb_rob[ROB_W*k +: ROB_W], wb_preg[PREG_W*k +: PREG_W],
             wb_data[DATA_W*k +: DATA_W], wb_arch[ARCH_W*k +: ARCH_W]} <= head[k];
            wb_src[SW*k +: SW] <= sel[k];
          end
        end
      end
    end
endmodule
